// File: rtl/aes_sbox_seq_sub.sv
// Serialized forward AES SubBytes: substitutes LANES bytes per cycle of a 128-bit state.
// Optional macro AES_SBOX_SEQ_PIPE_EN registers the S-box outputs before write-back.
module aes_sbox_seq_sub #(
    parameter int LANES = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state,
    output logic         busy
);

    localparam int NCYC = 16 / LANES;
    localparam int CW   = $clog2(NCYC) + 1;
    localparam logic [CW-1:0] LAST = CW'(NCYC - 1);

    if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_lanes_check
        $error("aes_sbox_seq_sub: LANES must be 1, 2, 4, 8 or 16");
    end

    // FIPS-197 forward S-box, entry 0 first
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic [1:0] {IDLE, SUB, FLUSH, DONE} state_t;

    state_t                 state, state_next;
    logic [CW-1:0]          cnt;
    logic [127:0]           wreg, wreg_next;
    logic [LANES-1:0][7:0]  sub;
    int                     grp;
    logic                   wb_en;
    int                     wb_grp;
    logic [LANES-1:0][7:0]  wb_data;

    // Lookup of the lane group selected by cnt
    always_comb begin
        grp = int'(cnt) % NCYC;
        for (int j = 0; j < LANES; j++) begin
            sub[j] = SBOX[wreg[(LANES * grp + j) * 8 +: 8]];
        end
    end

`ifdef AES_SBOX_SEQ_PIPE_EN
    logic [LANES-1:0][7:0] pipe_q;
    logic [CW-1:0]         pipe_grp;
    logic                  pipe_vld;

    always_ff @(posedge clk) begin
        if (reset) begin
            pipe_q   <= '0;
            pipe_grp <= '0;
            pipe_vld <= 1'b0;
        end else begin
            pipe_q   <= sub;
            pipe_grp <= cnt;
            pipe_vld <= (state == SUB);
        end
    end

    assign wb_en   = pipe_vld;
    assign wb_grp  = int'(pipe_grp) % NCYC;
    assign wb_data = pipe_q;
`else
    assign wb_en   = (state == SUB);
    assign wb_grp  = grp;
    assign wb_data = sub;
`endif

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        wreg_next = wreg;
        if (state == IDLE && in_valid) begin
            wreg_next = in_state;
        end else if (wb_en) begin
            for (int j = 0; j < LANES; j++) begin
                wreg_next[(LANES * wb_grp + j) * 8 +: 8] = wb_data[j];
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            wreg <= '0;
            cnt  <= '0;
        end else begin
            wreg <= wreg_next;
            if (state == IDLE && in_valid) begin
                cnt <= '0;
            end else if (state == SUB) begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (in_valid) state_next = SUB;
`ifdef AES_SBOX_SEQ_PIPE_EN
            SUB:   if (cnt == LAST) state_next = FLUSH;
`else
            SUB:   if (cnt == LAST) state_next = DONE;
`endif
            FLUSH: state_next = DONE;
            DONE:  if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
        busy      = (state != IDLE);
    end

    assign out_state = wreg;

endmodule

// File: tb/tb_aes_sbox_seq_sub.sv
// Scoreboard bench for aes_sbox_seq_sub at LANES = 1, 4 and 16 against a GF(2^8) S-box model.
// Honours AES_SBOX_SEQ_PIPE_EN for the extra latency cycle.
module tb_aes_sbox_seq_sub;

`ifdef AES_SBOX_SEQ_PIPE_EN
    localparam int EXTRA = 1;
`else
    localparam int EXTRA = 0;
`endif

    typedef struct {
        logic [127:0] d;
        int           t;
    } exp_t;

    logic clk = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
        logic [15:0] w = {x, x} << n;
        return w[15:8];
    endfunction

    // Multiplicative inverse (a^254) followed by the AES affine transform
    function automatic logic [7:0] sbox_f(input logic [7:0] a);
        logic [7:0] inv  = 8'h01;
        logic [7:0] base = a;
        for (int i = 0; i < 8; i++) begin
            if (i != 0) inv = gmul(inv, base);
            base = gmul(base, base);
        end
        return inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
    endfunction

    function automatic logic [127:0] model(input logic [127:0] d);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[8*i +: 8] = sbox_f(d[8*i +: 8]);
        return r;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    for (genvar k = 0; k < 3; k++) begin : g_dut
        localparam int L   = (k == 0) ? 1 : ((k == 1) ? 4 : 16);
        localparam int NC  = 16 / L;
        localparam int LAT = NC + 1 + EXTRA;

        logic         rst, iv, ir, ov, orr, bsy;
        logic [127:0] is, os;
        exp_t         q[$];
        logic         stream = 1'b0;
        logic         done = 1'b0;
        logic         prev = 1'b0;
        int           last_rise = 0;

        aes_sbox_seq_sub #(.LANES(L)) dut (
            .clk       (clk),
            .reset     (rst),
            .in_valid  (iv),
            .in_ready  (ir),
            .in_state  (is),
            .out_valid (ov),
            .out_ready (orr),
            .out_state (os),
            .busy      (bsy)
        );

        function automatic string nm(input string s);
            return $sformatf("L%0d_%s", L, s);
        endfunction

        task automatic send(input logic [127:0] d, input logic [127:0] e, input bit keep);
            int n = 0;
            @(negedge clk);
            iv = 1'b1;
            is = d;
            while (ir !== 1'b1 && n < 200) begin
                @(negedge clk);
                n++;
            end
            if (ir !== 1'b1) begin
                checks++;
                failures++;
                $display("FAIL %s got=busy expected=accept", nm("accept_timeout"));
            end else begin
                q.push_back('{d: e, t: cyc});
            end
            @(posedge clk);
            if (!keep) begin
                #1;
                iv = 1'b0;
            end
        endtask

        task automatic drain();
            int n = 0;
            while (q.size() != 0 && n < 300) begin
                @(negedge clk);
                n++;
            end
            check(nm("drain"), 128'(q.size()), 128'd0);
        endtask

        // Monitor: compares every presented output against the scoreboard front
        always begin
            @(negedge clk);
            #1;
            if (rst !== 1'b0) begin
                prev = 1'b0;
            end else begin
                if (ov === 1'b1) begin
                    if (q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL %s got=1 expected=0", nm("unexpected_out_valid"));
                    end else begin
                        if (!prev) begin
                            check(nm("latency"), 128'(cyc - q[0].t), 128'(LAT));
                            if (stream && last_rise != 0)
                                check(nm("period"), 128'(cyc - last_rise), 128'(NC + 2 + EXTRA));
                            last_rise = cyc;
                        end
                        check(nm("data"), os, q[0].d);
                        check(nm("in_ready_in_done"), 128'(ir), 128'd0);
                        if (orr === 1'b1) void'(q.pop_front());
                    end
                end
                if (!stream) last_rise = 0;
                prev = ov;
            end
        end

        initial begin
            logic [127:0] d;
            int n;
            rst = 1'b1;
            iv  = 1'b1;
            is  = {4{32'hdeadbeef}};
            orr = 1'b0;
            repeat (3) @(negedge clk);
            check(nm("rst_in_ready"), 128'(ir), 128'd1);
            check(nm("rst_out_valid"), 128'(ov), 128'd0);
            check(nm("rst_busy"), 128'(bsy), 128'd0);
            check(nm("rst_out_state"), os, 128'd0);
            rst = 1'b0;
            iv  = 1'b0;

            // All-zero block
            orr = 1'b1;
            send(128'd0, model(128'd0), 1'b0);
            @(negedge clk);
            check(nm("busy_in_sub"), 128'(bsy), 128'd1);
            check(nm("in_ready_in_sub"), 128'(ir), 128'd0);
            drain();
            @(negedge clk);
            check(nm("ready_after_handshake"), 128'(ir), 128'd1);

            // FIPS-197 Appendix B round 1
            send(128'h193de3bea0f4e22b9ac68d2ae9f84808, 128'hd42711aee0bf98f1b8b45de51e415230, 1'b0);
            drain();

            // Every byte value once
            for (int b = 0; b < 16; b++) begin
                for (int i = 0; i < 16; i++) d[8*i +: 8] = 8'(16 * b + i);
                send(d, model(d), 1'b0);
            end
            drain();

            // Back-pressure with a competing input
            orr = 1'b0;
            d = rand128();
            send(d, model(d), 1'b0);
            n = 0;
            while (ov !== 1'b1 && n < 100) begin
                @(negedge clk);
                n++;
            end
            check(nm("bp_valid_rise"), 128'(ov), 128'd1);
            for (int c = 0; c < 20; c++) begin
                @(negedge clk);
                iv = 1'b1;
                is = rand128();
            end
            check(nm("bp_valid_held"), 128'(ov), 128'd1);
            check(nm("bp_not_ready"), 128'(ir), 128'd0);
            @(negedge clk);
            iv  = 1'b0;
            orr = 1'b1;
            drain();
            d = rand128();
            send(d, model(d), 1'b0);
            drain();

            // Reset on the second busy cycle, with in_valid high during reset
            orr = 1'b0;
            d = rand128();
            send(d, model(d), 1'b0);
            @(negedge clk);
            @(negedge clk);
            rst = 1'b1;
            iv  = 1'b1;
            is  = rand128();
            q.delete();
            @(negedge clk);
            check(nm("midrst_in_ready"), 128'(ir), 128'd1);
            check(nm("midrst_out_valid"), 128'(ov), 128'd0);
            check(nm("midrst_out_state"), os, 128'd0);
            check(nm("midrst_busy"), 128'(bsy), 128'd0);
            @(negedge clk);
            check(nm("rst_no_accept"), 128'(bsy), 128'd0);
            rst = 1'b0;
            iv  = 1'b0;
            orr = 1'b1;
            repeat (NC + 6) @(negedge clk);
            check(nm("midrst_quiet"), 128'(ov), 128'd0);

            // Back-to-back stream
            stream = 1'b1;
            for (int b = 0; b < 8; b++) begin
                d = rand128();
                send(d, model(d), 1'b1);
            end
            @(negedge clk);
            iv = 1'b0;
            drain();
            stream = 1'b0;
            done = 1'b1;
        end
    end

    initial begin
        int n = 0;
        while (!(g_dut[0].done && g_dut[1].done && g_dut[2].done) && n < 60000) begin
            @(posedge clk);
            n++;
        end
        if (!(g_dut[0].done && g_dut[1].done && g_dut[2].done)) begin
            checks++;
            failures++;
            $display("FAIL global_timeout got=running expected=done");
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
